// File: rtl/nn_cfg_pkg.sv
// ============================================================================
// Module  : nn_cfg_pkg
// Purpose : Shared types and header field positions for the neuron config loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_cfg_pkg;

   typedef enum logic {
      CFG_WEIGHT = 1'b0,
      CFG_BIAS   = 1'b1
   } cfg_type_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } ld_state_e;

   localparam int TYPE_MSB   = 31;
   localparam int TYPE_LSB   = 30;
   localparam int LAYER_MSB  = 29;
   localparam int LAYER_LSB  = 24;
   localparam int NEURON_MSB = 23;
   localparam int NEURON_LSB = 16;
   localparam int CNT_MSB    = 15;
   localparam int CNT_LSB    = 0;

   localparam int LAYER_W  = LAYER_MSB - LAYER_LSB + 1;
   localparam int NEURON_W = NEURON_MSB - NEURON_LSB + 1;

endpackage

`default_nettype wire

// File: rtl/nn_config_loader_if.sv
// ============================================================================
// Module  : nn_config_loader_if
// Purpose : Host DMA packet stream (valid/ready/last) into the config loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface nn_config_loader_if #(
   parameter int DATA_W = 32
) ();

   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic              s_ready;

   modport master (
      output s_data,
      output s_valid,
      output s_last,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      input  s_last,
      output s_ready
   );

endinterface

`default_nettype wire

// File: rtl/nn_config_loader.sv
// ============================================================================
// Module  : nn_config_loader
// Purpose : Decodes weight/bias packets and sequences per-word strobes to neurons.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_config_loader
   import nn_cfg_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 16,
   parameter int MAX_LAYER = 4
) (
   input  logic               clk,
   input  logic               rst,
   nn_config_loader_if.slave  s,
   output logic               weight_valid_o,
   output logic               bias_valid_o,
   output logic [DATA_W-1:0]  weight_value_o,
   output logic [DATA_W-1:0]  bias_value_o,
   output logic [31:0]        config_layer_num_o,
   output logic [31:0]        config_neuron_num_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o
);

   ld_state_e             state_q,  state_d;
   cfg_type_e             type_q,   type_d;
   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic [LAYER_W-1:0]    layer_q,  layer_d;
   logic [NEURON_W-1:0]   neuron_q, neuron_d;
   logic [DATA_W-1:0]     wval_q,   wval_d;
   logic [DATA_W-1:0]     bval_q,   bval_d;
   logic                  wstb_q,   wstb_d;
   logic                  bstb_q,   bstb_d;
   logic                  done_q,   done_d;
   logic                  err_q,    err_d;

   logic                  accept;
   logic [1:0]            h_type;
   logic [LAYER_W-1:0]    h_layer;
   logic [NEURON_W-1:0]   h_neuron;
   logic [CNT_W-1:0]      h_cnt;
   logic                  hdr_ok;

   // Neurons never back-pressure, so the loader always takes a word.
   assign s.s_ready = 1'b1;
   assign accept    = s.s_valid & s.s_ready;

   assign h_type   = s.s_data[TYPE_MSB:TYPE_LSB];
   assign h_layer  = s.s_data[LAYER_MSB:LAYER_LSB];
   assign h_neuron = s.s_data[NEURON_MSB:NEURON_LSB];
   assign h_cnt    = CNT_W'(s.s_data[CNT_MSB:CNT_LSB]);
   assign hdr_ok   = ~h_type[1] && (32'(h_layer) <= 32'(MAX_LAYER));

   always_comb begin
      state_d  = state_q;
      type_d   = type_q;
      cnt_d    = cnt_q;
      layer_d  = layer_q;
      neuron_d = neuron_q;
      wval_d   = wval_q;
      bval_d   = bval_q;
      wstb_d   = 1'b0;
      bstb_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (hdr_ok) begin
                  layer_d  = h_layer;
                  neuron_d = h_neuron;
                  type_d   = cfg_type_e'(h_type[0]);
                  cnt_d    = h_cnt;
                  if (h_cnt == '0) begin
                     if (s.s_last) begin
                        done_d = 1'b1;
                     end else begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                     end
                  end else if (s.s_last) begin
                     err_d = 1'b1;
                  end else begin
                     state_d = LOAD;
                  end
               end else begin
                  err_d = 1'b1;
                  // A malformed single-word packet has already ended; nothing to drain.
                  if (!s.s_last) begin
                     state_d = DRAIN;
                  end
               end
            end
         end

         LOAD: begin
            if (accept) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (type_q == CFG_BIAS) begin
                  bstb_d = 1'b1;
                  bval_d = s.s_data;
               end else begin
                  wstb_d = 1'b1;
                  wval_d = s.s_data;
               end
               if (s.s_last) begin
                  state_d = IDLE;
                  if (cnt_q == CNT_W'(1)) begin
                     done_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (cnt_q == CNT_W'(1)) begin
                  err_d   = 1'b1;
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (accept && s.s_last) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         type_q   <= CFG_WEIGHT;
         cnt_q    <= '0;
         layer_q  <= '0;
         neuron_q <= '0;
         wval_q   <= '0;
         bval_q   <= '0;
         wstb_q   <= 1'b0;
         bstb_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         type_q   <= type_d;
         cnt_q    <= cnt_d;
         layer_q  <= layer_d;
         neuron_q <= neuron_d;
         wval_q   <= wval_d;
         bval_q   <= bval_d;
         wstb_q   <= wstb_d;
         bstb_q   <= bstb_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign weight_valid_o      = wstb_q;
   assign bias_valid_o        = bstb_q;
   assign weight_value_o      = wval_q;
   assign bias_value_o        = bval_q;
   assign config_layer_num_o  = 32'(layer_q);
   assign config_neuron_num_o = 32'(neuron_q);
   assign busy_o              = (state_q != IDLE);
   assign done_o              = done_q;
   assign err_o               = err_q;

endmodule

`default_nettype wire
